// File: rtl/srl_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the SRL-backed FWFT FIFO.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package srl_fifo_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // SRL address width for a FIFO of the given total depth (SRL holds depth-1 words).
    function automatic int addr_width_for(input int depth);
        int aw;
        aw = clog2(depth - 1);
        return (aw < 1) ? 1 : aw;
    endfunction

    // Occupancy must reach DEPTH = SRL words + output register, hence one extra bit.
    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit params_ok(input int data_width, input int depth,
                                     input int addr_width, input int af_thresh);
        return (data_width >= 1) && (depth >= 2) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (addr_width == addr_width_for(depth));
    endfunction

endpackage

// File: rtl/srl_fifo_shiftreg.sv
// Shift-register storage: write shifts every word up one slot, din enters slot 0; addressed read is combinational.
// Latency: write visible at read port after 1 edge; read is purely combinational.
// Backpressure: none here, caller gates shift_en. No reset so the array maps onto SRL primitives.
// Ports: clk, shift_en, din -> slot 0; rd_addr selects rd_dat.
module srl_fifo_shiftreg
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WORDS      = 15
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < WORDS; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Guarded mux: addresses beyond WORDS-1 (possible when WORDS is not a power of two) read zero.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_dat = mem[i];
            end
        end
    end

endmodule

// File: rtl/srl_fifo_fwft.sv
// First-word-fall-through FIFO: SRL storage of DEPTH-1 words plus one registered output word.
// Latency: write to if_empty_n = 2 edges on an empty FIFO; reads sustain 1 word/cycle.
// Backpressure: writes ignored while if_full_n is low, reads ignored while if_empty_n is low; flags come from registered state only.
// Ports: clk/reset; write side if_write_ce, if_write, if_din, if_full_n, if_almost_full;
//        read side if_read_ce, if_read, if_dout, if_empty_n; occupancy if_num_data_valid.
module srl_fifo_fwft
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);

    localparam int OCC_W = occ_width(ADDR_WIDTH);
    localparam int WORDS = DEPTH - 1;

    if (!params_ok(DATA_WIDTH, DEPTH, ADDR_WIDTH, AF_THRESH)) begin : g_bad_params
        $error("srl_fifo_fwft: illegal DATA_WIDTH/DEPTH/ADDR_WIDTH/AF_THRESH combination");
    end

    logic [OCC_W-1:0]      srl_cnt;
    logic [OCC_W-1:0]      srl_cnt_nxt;
    logic [OCC_W-1:0]      occ;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] srl_rd_dat;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr;
    logic                  rd;
    logic                  load;

    assign occ               = srl_cnt + OCC_W'(out_valid);
    // Held low during reset so a producer cannot push into a FIFO that is being cleared.
    assign if_full_n         = !reset && (occ < OCC_W'(DEPTH));
    assign if_almost_full    = (occ >= OCC_W'(AF_THRESH));
    assign if_empty_n        = out_valid;
    assign if_dout           = out_reg;
    assign if_num_data_valid = occ;

    assign wr   = if_write && if_write_ce && if_full_n;
    assign rd   = if_read && if_read_ce && out_valid;
    // Refill the output word whenever it is empty or being consumed this cycle.
    assign load = (srl_cnt != '0) && (!out_valid || rd);

    // Oldest SRL word sits at srl_cnt-1; the value is taken before this edge's shift, so a
    // concurrent write cannot disturb the word being loaded. Unused when srl_cnt == 0.
    assign rd_addr     = ADDR_WIDTH'(srl_cnt - OCC_W'(1));
    assign srl_cnt_nxt = srl_cnt + OCC_W'(wr) - OCC_W'(load);

    srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORDS      (WORDS)
    ) u_shiftreg (
        .clk      (clk),
        .shift_en (wr),
        .din      (if_din),
        .rd_addr  (rd_addr),
        .rd_dat   (srl_rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srl_cnt   <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else begin
            srl_cnt   <= srl_cnt_nxt;
            out_valid <= load || (out_valid && !rd);
            if (load) begin
                out_reg <= srl_rd_dat;
            end
        end
    end

    // Full gating on wr and the srl_cnt!=0 term on load keep the SRL count in range;
    // an underflow would wrap to a large value and trip this too.
    a_srl_cnt_range : assert property (@(posedge clk) disable iff (reset)
        srl_cnt_nxt <= OCC_W'(WORDS));

endmodule
